// File: rtl/sd_card_fsm_if.sv
// Command-layer bus between the card command receiver, response transmitter,
// card data engines and the sd_card_fsm responder.
interface sd_card_fsm_if;
  logic         icmd_valid;
  logic         icrc_err;
  logic [5:0]   icmd_index;
  logic [31:0]  icmd_arg;
  logic         iread_done;
  logic         ibusy;
  logic         oresp_start;
  logic [2:0]   oresp_type;
  logic [5:0]   oresp_index;
  logic [119:0] oresp_payload;
  logic         ostart_tx_d;
  logic         ostart_rx_d;
  logic         ostop_d;
  logic [31:0]  oblk_addr;
  logic [3:0]   ocard_state;

  modport slave (
    input  icmd_valid, icrc_err, icmd_index, icmd_arg, iread_done, ibusy,
    output oresp_start, oresp_type, oresp_index, oresp_payload,
           ostart_tx_d, ostart_rx_d, ostop_d, oblk_addr, ocard_state
  );

  modport master (
    output icmd_valid, icrc_err, icmd_index, icmd_arg, iread_done, ibusy,
    input  oresp_start, oresp_type, oresp_index, oresp_payload,
           ostart_tx_d, ostart_rx_d, ostop_d, oblk_addr, ocard_state
  );
endinterface

// File: rtl/sd_card_fsm.sv
// Card-side SD command-layer responder: card state machine, RCA, APP_CMD and status.
// Define SD_CARD_LEGACY_EN for a standard-capacity card (byte addressing, OCR[30]=0).
//
// state | meaning
// IDLE  | after power-up or CMD0, waiting for ACMD41 to complete
// READY | power-up done, waiting for CMD2
// IDENT | CID sent, waiting for CMD3
// STBY  | addressed, deselected
// TRAN  | selected, ready for data commands
// DATA  | card sending data to host
// RCV   | card receiving data from host
// PRG   | programming, waiting for busy to drop
// INA   | inactive, only CMD0 leaves
module sd_card_fsm #(
  parameter logic [15:0]  RCA             = 16'h1234,
  parameter logic [119:0] CID             = 120'h0,
  parameter logic [119:0] CSD             = 120'h0,
  parameter int unsigned  OCR_DELAY       = 3,
  parameter logic [31:0]  CAPACITY_BLOCKS = 32'd2048
) (
  input logic          iclk,
  input logic          irst,
  sd_card_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_READY = 4'd1,
    S_IDENT = 4'd2,
    S_STBY  = 4'd3,
    S_TRAN  = 4'd4,
    S_DATA  = 4'd5,
    S_RCV   = 4'd6,
    S_PRG   = 4'd7,
    S_INA   = 4'd9
  } state_t;

  localparam logic [2:0] RT_R1 = 3'd1;
  localparam logic [2:0] RT_R2 = 3'd2;
  localparam logic [2:0] RT_R3 = 3'd3;
  localparam logic [2:0] RT_R6 = 3'd6;
  localparam logic [2:0] RT_R7 = 3'd7;

`ifdef SD_CARD_LEGACY_EN
  localparam logic OCR_CCS = 1'b0;
`else
  localparam logic OCR_CCS = 1'b1;
`endif

  state_t         state, state_n;
  logic           app, app_n;
  logic           oor, oor_n, aerr, aerr_n, crc, crc_n, ill, ill_n;
  logic [3:0]     cnt, cnt_n;
  logic [15:0]    rca, rca_n;
  logic           resp_start, resp_start_n;
  logic [2:0]     resp_type, resp_type_n;
  logic [5:0]     resp_index, resp_index_n;
  logic [119:0]   resp_payload, resp_payload_n;
  logic           tx, tx_n, rx, rx_n, stop, stop_n;
  logic [31:0]    blk, blk_n;

  logic           legal, app_after, send_r1, send_r6, ready, rca_match;
  logic           addr_bad, range_bad;
  logic [3:0]     cnt_inc;
  logic [31:0]    addr_blk, status;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state        <= S_IDLE;
      app          <= 1'b0;
      oor          <= 1'b0;
      aerr         <= 1'b0;
      crc          <= 1'b0;
      ill          <= 1'b0;
      cnt          <= 4'd0;
      rca          <= 16'd0;
      resp_start   <= 1'b0;
      resp_type    <= 3'd0;
      resp_index   <= 6'd0;
      resp_payload <= 120'd0;
      tx           <= 1'b0;
      rx           <= 1'b0;
      stop         <= 1'b0;
      blk          <= 32'd0;
    end else begin
      state        <= state_n;
      app          <= app_n;
      oor          <= oor_n;
      aerr         <= aerr_n;
      crc          <= crc_n;
      ill          <= ill_n;
      cnt          <= cnt_n;
      rca          <= rca_n;
      resp_start   <= resp_start_n;
      resp_type    <= resp_type_n;
      resp_index   <= resp_index_n;
      resp_payload <= resp_payload_n;
      tx           <= tx_n;
      rx           <= rx_n;
      stop         <= stop_n;
      blk          <= blk_n;
    end
  end

  always_comb begin
    state_n        = state;
    app_n          = app;
    oor_n          = oor;
    aerr_n         = aerr;
    crc_n          = crc;
    ill_n          = ill;
    cnt_n          = cnt;
    rca_n          = rca;
    resp_start_n   = 1'b0;
    resp_type_n    = resp_type;
    resp_index_n   = resp_index;
    resp_payload_n = resp_payload;
    tx_n           = 1'b0;
    rx_n           = 1'b0;
    stop_n         = 1'b0;
    blk_n          = blk;
    legal          = 1'b1;
    app_after      = 1'b0;
    send_r1        = 1'b0;
    send_r6        = 1'b0;
    ready          = 1'b0;
    status         = 32'd0;
    cnt_inc        = (cnt == 4'hF) ? cnt : cnt + 4'd1;
    rca_match      = (bus.icmd_arg[31:16] == rca);
`ifdef SD_CARD_LEGACY_EN
    addr_blk       = {9'd0, bus.icmd_arg[31:9]};
    addr_bad       = |bus.icmd_arg[8:0];
`else
    addr_blk       = bus.icmd_arg;
    addr_bad       = 1'b0;
`endif
    range_bad      = (addr_blk >= CAPACITY_BLOCKS);

    // Autonomous exits; any command-driven transition below takes priority.
    if (state == S_PRG && !bus.ibusy)
      state_n = S_TRAN;
    else if (state == S_DATA && bus.iread_done)
      state_n = S_TRAN;

    if (bus.icrc_err) begin
      crc_n = 1'b1;
      app_n = 1'b0;
    end else if (bus.icmd_valid && bus.icmd_index == 6'd0) begin
      state_n = S_IDLE;
      app_n   = 1'b0;
      oor_n   = 1'b0;
      aerr_n  = 1'b0;
      crc_n   = 1'b0;
      ill_n   = 1'b0;
      cnt_n   = 4'd0;
      rca_n   = 16'd0;
    end else if (bus.icmd_valid) begin
      if (state == S_INA || (state == S_PRG && bus.icmd_index != 6'd13)) begin
        legal = 1'b0;
      end else begin
        case (bus.icmd_index)
          6'd8: begin
            if (state == S_IDLE) begin
              resp_start_n   = 1'b1;
              resp_type_n    = RT_R7;
              resp_index_n   = 6'd8;
              resp_payload_n = {88'd0, 20'd0, 4'h1, bus.icmd_arg[7:0]};
            end else legal = 1'b0;
          end
          6'd55: begin
            app_after = 1'b1;
            send_r1   = 1'b1;
          end
          6'd41: begin
            if (app && (state == S_IDLE || state == S_READY)) begin
              cnt_n          = cnt_inc;
              ready          = ({28'd0, cnt_inc} >= 32'(OCR_DELAY));
              resp_start_n   = 1'b1;
              resp_type_n    = RT_R3;
              resp_index_n   = 6'h3F;
              resp_payload_n = {88'd0, ready, OCR_CCS, 30'h00FF8000};
              if (ready) state_n = S_READY;
            end else legal = 1'b0;
          end
          6'd2: begin
            if (state == S_READY) begin
              resp_start_n   = 1'b1;
              resp_type_n    = RT_R2;
              resp_index_n   = 6'h3F;
              resp_payload_n = CID;
              state_n        = S_IDENT;
            end else legal = 1'b0;
          end
          6'd3: begin
            if (state == S_IDENT || state == S_STBY) begin
              rca_n   = RCA;
              send_r6 = 1'b1;
              state_n = S_STBY;
            end else legal = 1'b0;
          end
          6'd9: begin
            if (state == S_STBY && rca_match) begin
              resp_start_n   = 1'b1;
              resp_type_n    = RT_R2;
              resp_index_n   = 6'h3F;
              resp_payload_n = CSD;
            end else legal = 1'b0;
          end
          6'd7: begin
            if (state == S_STBY && rca_match) begin
              send_r1 = 1'b1;
              state_n = S_TRAN;
            end else if (state == S_TRAN && !rca_match) begin
              state_n = S_STBY;
            end else legal = 1'b0;
          end
          6'd6: begin
            if (state == S_TRAN) begin
              send_r1 = 1'b1;
              tx_n    = 1'b1;
              state_n = S_DATA;
            end else legal = 1'b0;
          end
          6'd23: begin
            if (app && state == S_TRAN) send_r1 = 1'b1;
            else legal = 1'b0;
          end
          6'd13: begin
            if (rca_match && state >= S_STBY && state <= S_PRG) send_r1 = 1'b1;
            else legal = 1'b0;
          end
          6'd18, 6'd25: begin
            if (state == S_TRAN) begin
              send_r1 = 1'b1;
              blk_n   = addr_blk;
              if (addr_bad)  aerr_n = 1'b1;
              if (range_bad) oor_n  = 1'b1;
              if (!addr_bad && !range_bad) begin
                if (bus.icmd_index == 6'd18) begin
                  tx_n    = 1'b1;
                  state_n = S_DATA;
                end else begin
                  rx_n    = 1'b1;
                  state_n = S_RCV;
                end
              end
            end else legal = 1'b0;
          end
          6'd12: begin
            if (state == S_DATA) begin
              send_r1 = 1'b1;
              stop_n  = 1'b1;
              state_n = S_TRAN;
            end else if (state == S_RCV) begin
              send_r1 = 1'b1;
              stop_n  = 1'b1;
              state_n = S_PRG;
            end else legal = 1'b0;
          end
          6'd15: begin
            if (rca_match && state != S_IDLE) state_n = S_INA;
            else legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end

      if (!legal) ill_n = 1'b1;
      app_n  = app_after;
      // Errors raised by this very command are reported in its own response.
      status = {oor_n, aerr_n, 6'd0, crc_n, ill_n, 9'd0, 4'(state), ~bus.ibusy,
                2'd0, app_after, 5'd0};
      if (send_r1) begin
        resp_start_n   = 1'b1;
        resp_type_n    = RT_R1;
        resp_index_n   = bus.icmd_index;
        resp_payload_n = {88'd0, status};
        oor_n          = 1'b0;
        aerr_n         = 1'b0;
        crc_n          = 1'b0;
        ill_n          = 1'b0;
      end
      if (send_r6) begin
        resp_start_n   = 1'b1;
        resp_type_n    = RT_R6;
        resp_index_n   = 6'd3;
        resp_payload_n = {88'd0, RCA, status[23], status[22], status[19], status[12:0]};
        crc_n          = 1'b0;
        ill_n          = 1'b0;
      end
    end
  end

  assign bus.oresp_start   = resp_start;
  assign bus.oresp_type    = resp_type;
  assign bus.oresp_index   = resp_index;
  assign bus.oresp_payload = resp_payload;
  assign bus.ostart_tx_d   = tx;
  assign bus.ostart_rx_d   = rx;
  assign bus.ostop_d       = stop;
  assign bus.oblk_addr     = blk;
  assign bus.ocard_state   = state;

endmodule

// File: tb/tb_sd_card_fsm.sv
// Bench for sd_card_fsm: directed bring-up/read/write/error scenarios plus a
// randomized command stream checked against a command-table reference model.
module tb_sd_card_fsm;
  localparam logic [119:0] CID_V = 120'hEEC1D0_0102_0304_0506_0708_090A_0B0C;
  localparam logic [119:0] CSD_V = 120'h55C5D0_1112_1314_1516_1718_191A_1B1C;
`ifdef SD_CARD_LEGACY_EN
  localparam logic [31:0] BSCALE  = 32'd512;
  localparam logic [31:0] OCR_CCS = 32'h0;
`else
  localparam logic [31:0] BSCALE  = 32'd1;
  localparam logic [31:0] OCR_CCS = 32'h40000000;
`endif

  logic iclk = 1'b0;
  logic irst = 1'b1;
  always #5 iclk = ~iclk;

  sd_card_fsm_if bus ();
  sd_card_fsm #(.CID(CID_V), .CSD(CSD_V)) dut (.iclk(iclk), .irst(irst), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Reference model: card state as plain integers following the command table.
  int           m_state, m_cnt;
  bit           m_app, m_oor, m_aerr, m_crc, m_ill;
  logic [15:0]  m_rca;
  bit           e_start, e_tx, e_rx, e_stop;
  logic [2:0]   e_type;
  logic [5:0]   e_index;
  logic [119:0] e_payload;
  logic [31:0]  e_blk;

  task automatic model_clear_card();
    m_state = 0; m_cnt = 0; m_app = 0; m_oor = 0; m_aerr = 0; m_crc = 0; m_ill = 0;
    m_rca = 16'h0;
  endtask

  task automatic model_reset();
    model_clear_card();
    e_start = 0; e_tx = 0; e_rx = 0; e_stop = 0;
    e_type = 0; e_index = 0; e_payload = 0; e_blk = 0;
  endtask

  task automatic model_edge(input bit v, input bit ce, input logic [5:0] idx,
                            input logic [31:0] arg, input bit busy, input bit rd);
    int s0, ns;
    bit legal, app_after, match, ready, send1, send6, abad, rbad;
    logic [31:0] blk, st, ocr;
    s0 = m_state; ns = s0; legal = 1; app_after = 0; send1 = 0; send6 = 0;
    e_start = 0; e_tx = 0; e_rx = 0; e_stop = 0;
    match = (arg[31:16] == m_rca);
`ifdef SD_CARD_LEGACY_EN
    blk = arg / 512; abad = (arg % 512) != 0;
`else
    blk = arg; abad = 0;
`endif
    rbad = (blk >= 2048);
    if (ce) begin
      m_crc = 1; m_app = 0;
    end else if (v && idx == 0) begin
      model_clear_card(); ns = 0;
    end else if (v) begin
      if (s0 == 9 || (s0 == 7 && idx != 13)) legal = 0;
      else if (idx == 8) begin
        if (s0 == 0) begin
          e_start = 1; e_type = 7; e_index = 8;
          e_payload = {88'd0, 20'd0, 4'h1, arg[7:0]};
        end else legal = 0;
      end else if (idx == 55) begin
        app_after = 1; send1 = 1;
      end else if (idx == 41) begin
        if (m_app && (s0 == 0 || s0 == 1)) begin
          m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
          ready = (m_cnt >= 3);
          ocr = 32'h00FF8000 | OCR_CCS | (ready ? 32'h80000000 : 32'h0);
          e_start = 1; e_type = 3; e_index = 6'h3F; e_payload = {88'd0, ocr};
          if (ready) ns = 1;
        end else legal = 0;
      end else if (idx == 2) begin
        if (s0 == 1) begin
          e_start = 1; e_type = 2; e_index = 6'h3F; e_payload = CID_V; ns = 2;
        end else legal = 0;
      end else if (idx == 3) begin
        if (s0 == 2 || s0 == 3) begin m_rca = 16'h1234; send6 = 1; ns = 3; end
        else legal = 0;
      end else if (idx == 9) begin
        if (s0 == 3 && match) begin
          e_start = 1; e_type = 2; e_index = 6'h3F; e_payload = CSD_V;
        end else legal = 0;
      end else if (idx == 7) begin
        if (s0 == 3 && match) begin send1 = 1; ns = 4; end
        else if (s0 == 4 && !match) ns = 3;
        else legal = 0;
      end else if (idx == 6) begin
        if (s0 == 4) begin send1 = 1; e_tx = 1; ns = 5; end
        else legal = 0;
      end else if (idx == 23) begin
        if (m_app && s0 == 4) send1 = 1; else legal = 0;
      end else if (idx == 13) begin
        if (match && s0 >= 3 && s0 <= 7) send1 = 1; else legal = 0;
      end else if (idx == 18 || idx == 25) begin
        if (s0 == 4) begin
          send1 = 1; e_blk = blk;
          if (abad) m_aerr = 1;
          if (rbad) m_oor = 1;
          if (!abad && !rbad) begin
            if (idx == 18) begin e_tx = 1; ns = 5; end
            else begin e_rx = 1; ns = 6; end
          end
        end else legal = 0;
      end else if (idx == 12) begin
        if (s0 == 5) begin send1 = 1; e_stop = 1; ns = 4; end
        else if (s0 == 6) begin send1 = 1; e_stop = 1; ns = 7; end
        else legal = 0;
      end else if (idx == 15) begin
        if (match && s0 != 0) ns = 9; else legal = 0;
      end else legal = 0;

      if (!legal) m_ill = 1;
      m_app = app_after;
      st = {m_oor, m_aerr, 6'd0, m_crc, m_ill, 9'd0, s0[3:0], ~busy, 2'd0, app_after, 5'd0};
      if (send1) begin
        e_start = 1; e_type = 1; e_index = idx; e_payload = {88'd0, st};
        m_oor = 0; m_aerr = 0; m_crc = 0; m_ill = 0;
      end
      if (send6) begin
        e_start = 1; e_type = 6; e_index = 3;
        e_payload = {88'd0, 16'h1234, st[23], st[22], 1'b0, st[12:0]};
        m_crc = 0; m_ill = 0;
      end
    end
    if (ns == s0) begin
      if (s0 == 7 && !busy) ns = 4;
      else if (s0 == 5 && rd) ns = 4;
    end
    m_state = ns;
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs settled.
  task automatic step(input bit v, input bit ce, input logic [5:0] idx,
                      input logic [31:0] arg, input bit busy, input bit rd);
    bus.icmd_valid = v; bus.icrc_err = ce; bus.icmd_index = idx;
    bus.icmd_arg = arg; bus.ibusy = busy; bus.iread_done = rd;
    model_edge(v, ce, idx, arg, busy, rd);
    @(negedge iclk);
    bus.icmd_valid = 0; bus.icrc_err = 0; bus.iread_done = 0;
  endtask

  task automatic cmd(input logic [5:0] idx, input logic [31:0] arg, input bit busy);
    step(1, 0, idx, arg, busy, 0);
  endtask

  task automatic bring_up();
    cmd(0, 0, 0);
    cmd(8, 32'h1AA, 0);
    for (int k = 0; k < 20 && m_state != 1; k++) begin
      cmd(55, 0, 0);
      cmd(41, 32'h40FF8000, 0);
    end
    cmd(2, 0, 0);
    cmd(3, 0, 0);
    cmd(7, 32'h12340000, 0);
  endtask

  task automatic test_reset();
    model_reset();
    tests++;
    if ({bus.oresp_start, bus.oresp_type, bus.oresp_index, bus.ostart_tx_d, bus.ostart_rx_d,
         bus.ostop_d, bus.ocard_state} !== 17'd0 || bus.oresp_payload !== 120'd0 ||
        bus.oblk_addr !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: got start=%b type=%0d state=%0d blk=%h, want all zero",
               bus.oresp_start, bus.oresp_type, bus.ocard_state, bus.oblk_addr);
    end
  endtask

  task automatic test_identification();
    logic [31:0] want;
    cmd(0, 0, 0);
    tests++;
    if (bus.oresp_start !== 1'b0) begin
      fails++; $display("FAIL cmd0_no_resp: got start=%b want 0", bus.oresp_start);
    end
    cmd(8, 32'h1AA, 0);
    tests++;
    if (bus.oresp_start !== 1'b1 || bus.oresp_type !== 3'd7 || bus.oresp_payload[31:0] !== 32'h1AA) begin
      fails++;
      $display("FAIL cmd8_r7: got start=%b type=%0d pl=%h want 1/7/000001aa",
               bus.oresp_start, bus.oresp_type, bus.oresp_payload[31:0]);
    end
    for (int i = 0; i < 3; i++) begin
      cmd(55, 0, 0);
      tests++;
      if (bus.oresp_type !== 3'd1 || bus.oresp_payload[5] !== 1'b1) begin
        fails++;
        $display("FAIL cmd55_app[%0d]: got type=%0d bit5=%b want 1/1", i, bus.oresp_type, bus.oresp_payload[5]);
      end
      cmd(41, 32'h40FF8000, 0);
      want = (i < 2) ? (32'h00FF8000 | OCR_CCS) : (32'h80FF8000 | OCR_CCS);
      tests++;
      if (bus.oresp_start !== 1'b1 || bus.oresp_type !== 3'd3 || bus.oresp_payload[31:0] !== want) begin
        fails++;
        $display("FAIL acmd41_ocr[%0d]: got type=%0d ocr=%h want 3/%h", i, bus.oresp_type,
                 bus.oresp_payload[31:0], want);
      end
    end
    tests++;
    if (bus.ocard_state !== 4'd1) begin
      fails++; $display("FAIL ready_state: got %0d want 1", bus.ocard_state);
    end
  endtask

  task automatic test_addressing();
    cmd(2, 0, 0);
    tests++;
    if (bus.oresp_type !== 3'd2 || bus.oresp_index !== 6'h3F || bus.oresp_payload !== CID_V) begin
      fails++; $display("FAIL cmd2_cid: got type=%0d pl=%h want 2/%h", bus.oresp_type, bus.oresp_payload, CID_V);
    end
    cmd(3, 0, 0);
    tests++;
    if (bus.oresp_type !== 3'd6 || bus.oresp_payload[31:16] !== 16'h1234 || bus.ocard_state !== 4'd3) begin
      fails++;
      $display("FAIL cmd3_r6: got type=%0d rca=%h state=%0d want 6/1234/3", bus.oresp_type,
               bus.oresp_payload[31:16], bus.ocard_state);
    end
    cmd(9, 32'h12340000, 0);
    tests++;
    if (bus.oresp_type !== 3'd2 || bus.oresp_payload !== CSD_V) begin
      fails++; $display("FAIL cmd9_csd: got type=%0d pl=%h want 2/%h", bus.oresp_type, bus.oresp_payload, CSD_V);
    end
    cmd(7, 32'h12340000, 0);
    tests++;
    if (bus.oresp_type !== 3'd1 || bus.oresp_payload[12:9] !== 4'd3 || bus.ocard_state !== 4'd4) begin
      fails++;
      $display("FAIL cmd7_select: got type=%0d st=%0d state=%0d want 1/3/4", bus.oresp_type,
               bus.oresp_payload[12:9], bus.ocard_state);
    end
  endtask

  task automatic test_read();
    cmd(18, 32'd5 * BSCALE, 0);
    tests++;
    if (bus.oresp_payload[12:9] !== 4'd4 || bus.ostart_tx_d !== 1'b1 || bus.oblk_addr !== 32'd5 ||
        bus.ocard_state !== 4'd5) begin
      fails++;
      $display("FAIL cmd18_read: got st=%0d tx=%b blk=%0d state=%0d want 4/1/5/5",
               bus.oresp_payload[12:9], bus.ostart_tx_d, bus.oblk_addr, bus.ocard_state);
    end
    cmd(12, 0, 0);
    tests++;
    if (bus.ostop_d !== 1'b1 || bus.oresp_start !== 1'b1 || bus.ocard_state !== 4'd4) begin
      fails++;
      $display("FAIL cmd12_read_stop: got stop=%b start=%b state=%0d want 1/1/4", bus.ostop_d,
               bus.oresp_start, bus.ocard_state);
    end
  endtask

  task automatic test_write();
    cmd(25, 32'd7 * BSCALE, 0);
    tests++;
    if (bus.ostart_rx_d !== 1'b1 || bus.oblk_addr !== 32'd7 || bus.ocard_state !== 4'd6) begin
      fails++;
      $display("FAIL cmd25_write: got rx=%b blk=%0d state=%0d want 1/7/6", bus.ostart_rx_d,
               bus.oblk_addr, bus.ocard_state);
    end
    cmd(12, 0, 1);
    tests++;
    if (bus.ostop_d !== 1'b1 || bus.ocard_state !== 4'd7) begin
      fails++; $display("FAIL cmd12_write_stop: got stop=%b state=%0d want 1/7", bus.ostop_d, bus.ocard_state);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        cmd(13, 32'h12340000, 1);
        tests++;
        if (bus.oresp_start !== 1'b1 || bus.oresp_payload[12:9] !== 4'd7 || bus.oresp_payload[8] !== 1'b0) begin
          fails++;
          $display("FAIL cmd13_in_prg: got start=%b st=%0d rdy=%b want 1/7/0", bus.oresp_start,
                   bus.oresp_payload[12:9], bus.oresp_payload[8]);
        end
      end else step(0, 0, 0, 0, 1, 0);
      tests++;
      if (bus.ocard_state !== 4'd7) begin
        fails++; $display("FAIL prg_hold[%0d]: got state %0d want 7", i, bus.ocard_state);
      end
    end
    step(0, 0, 0, 0, 0, 0);
    tests++;
    if (bus.ocard_state !== 4'd4) begin
      fails++; $display("FAIL prg_exit: got state %0d want 4", bus.ocard_state);
    end
  endtask

  task automatic test_errors();
    step(0, 1, 13, 32'h12340000, 0, 0);
    tests++;
    if (bus.oresp_start !== 1'b0) begin
      fails++; $display("FAIL crc_no_resp: got start=%b want 0", bus.oresp_start);
    end
    cmd(13, 32'h12340000, 0);
    tests++;
    if (bus.oresp_payload[23] !== 1'b1) begin
      fails++; $display("FAIL crc_reported: got bit23=%b want 1", bus.oresp_payload[23]);
    end
    cmd(13, 32'h12340000, 0);
    tests++;
    if (bus.oresp_payload[23] !== 1'b0) begin
      fails++; $display("FAIL crc_cleared: got bit23=%b want 0", bus.oresp_payload[23]);
    end
    cmd(2, 0, 0);
    tests++;
    if (bus.oresp_start !== 1'b0 || bus.ocard_state !== 4'd4) begin
      fails++; $display("FAIL illegal_silent: got start=%b state=%0d want 0/4", bus.oresp_start, bus.ocard_state);
    end
    cmd(13, 32'h12340000, 0);
    tests++;
    if (bus.oresp_payload[22] !== 1'b1) begin
      fails++; $display("FAIL illegal_reported: got bit22=%b want 1", bus.oresp_payload[22]);
    end
    cmd(18, 32'd2048 * BSCALE, 0);
    tests++;
    if (bus.oresp_payload[31] !== 1'b1 || bus.ostart_tx_d !== 1'b0 || bus.ocard_state !== 4'd4) begin
      fails++;
      $display("FAIL out_of_range: got bit31=%b tx=%b state=%0d want 1/0/4", bus.oresp_payload[31],
               bus.ostart_tx_d, bus.ocard_state);
    end
  endtask

  task automatic test_random();
    logic [5:0] tab [16] = '{6'd0, 6'd2, 6'd3, 6'd6, 6'd7, 6'd8, 6'd9, 6'd12,
                             6'd13, 6'd15, 6'd18, 6'd23, 6'd25, 6'd41, 6'd55, 6'd1};
    logic [5:0] idx;
    logic [31:0] arg;
    bit v, ce, busy, rd;
    for (int i = 0; i < 400; i++) begin
      idx = tab[$urandom_range(0, 15)];
      if (idx == 0 && $urandom_range(0, 3) != 0) idx = 6'd13;
      if (idx == 1) idx = 6'($urandom_range(1, 63));
      arg = ($urandom_range(0, 1) == 1) ? {16'h1234, 16'($urandom)} : $urandom;
      if (idx == 18 || idx == 25) begin
        arg = 32'($urandom_range(0, 2100)) * BSCALE;
        if ($urandom_range(0, 7) == 0) arg = arg + 32'($urandom_range(0, 511));
      end
      v = ($urandom_range(0, 4) != 0);
      ce = ($urandom_range(0, 11) == 0);
      busy = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 5) == 0);
      step(v, ce, idx, arg, busy, rd);
      tests++;
      if (bus.oresp_start !== e_start) begin
        fails++; $display("FAIL rand[%0d] start cmd%0d: got %b want %b", i, idx, bus.oresp_start, e_start);
      end
      tests++;
      if (bus.oresp_type !== e_type || bus.oresp_index !== e_index) begin
        fails++;
        $display("FAIL rand[%0d] type/index cmd%0d: got %0d/%0d want %0d/%0d", i, idx,
                 bus.oresp_type, bus.oresp_index, e_type, e_index);
      end
      tests++;
      if (bus.oresp_payload !== e_payload) begin
        fails++; $display("FAIL rand[%0d] payload cmd%0d: got %h want %h", i, idx, bus.oresp_payload, e_payload);
      end
      tests++;
      if ({bus.ostart_tx_d, bus.ostart_rx_d, bus.ostop_d} !== {e_tx, e_rx, e_stop}) begin
        fails++;
        $display("FAIL rand[%0d] data_pulses cmd%0d: got %b%b%b want %b%b%b", i, idx, bus.ostart_tx_d,
                 bus.ostart_rx_d, bus.ostop_d, e_tx, e_rx, e_stop);
      end
      tests++;
      if (bus.oblk_addr !== e_blk) begin
        fails++; $display("FAIL rand[%0d] blk_addr: got %h want %h", i, bus.oblk_addr, e_blk);
      end
      tests++;
      if (bus.ocard_state !== 4'(m_state)) begin
        fails++; $display("FAIL rand[%0d] state cmd%0d: got %0d want %0d", i, idx, bus.ocard_state, m_state);
      end
      if ((v && !ce && idx == 0) || (m_state == 9 && $urandom_range(0, 7) == 0)) bring_up();
    end
  endtask

  task automatic test_reset_mid_data();
    bring_up();
    cmd(18, 32'd1 * BSCALE, 0);
    tests++;
    if (bus.ocard_state !== 4'd5) begin
      fails++; $display("FAIL pre_reset_data: got state %0d want 5", bus.ocard_state);
    end
    #2 irst = 1'b1;
    #1;
    tests++;
    if ({bus.oresp_start, bus.oresp_type, bus.oresp_index, bus.ostart_tx_d, bus.ostart_rx_d,
         bus.ostop_d, bus.ocard_state} !== 17'd0 || bus.oresp_payload !== 120'd0 ||
        bus.oblk_addr !== 32'd0) begin
      fails++;
      $display("FAIL async_reset: got type=%0d state=%0d blk=%h want all zero", bus.oresp_type,
               bus.ocard_state, bus.oblk_addr);
    end
    @(negedge iclk);
    irst = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.icmd_valid = 0; bus.icrc_err = 0; bus.icmd_index = 0; bus.icmd_arg = 0;
    bus.iread_done = 0; bus.ibusy = 0;
    repeat (3) @(negedge iclk);
    irst = 1'b0;
    test_reset();
    test_identification();
    test_addressing();
    test_read();
    test_write();
    test_errors();
    test_random();
    test_reset_mid_data();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
